// File: rtl/freq_gate_counter_pkg.sv
// rtl/freq_gate_counter_pkg.sv - shared state encodings and default sizing for the gated frequency counter
package freq_gate_counter_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_COUNT = 1'b1
    } fgc_state_e;

    // Defaults give a 1 s window at 50 MHz; readout logic reuses these.
    localparam int DEF_GATE_CYCLES = 50_000_000;
    localparam int DEF_GATE_W      = 26;
    localparam int DEF_CNT_W       = 32;

endpackage

// File: rtl/freq_gate_counter_gate_timer.sv
// rtl/freq_gate_counter_gate_timer.sv - window timer, 0..GATE_CYCLES-1 with terminal-count pulse
module freq_gate_counter_gate_timer
    import freq_gate_counter_pkg::*;
#(
    parameter int GATE_CYCLES = DEF_GATE_CYCLES,
    parameter int GATE_W      = DEF_GATE_W
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic run,
    output logic tc
);

    localparam logic [GATE_W-1:0] LAST = GATE_W'(GATE_CYCLES - 1);

    logic [GATE_W-1:0] cnt_q;
    logic [GATE_W-1:0] cnt_d;

    assign tc = run && (cnt_q == LAST);

    // Wrapping on tc lets back-to-back windows start with no dead cycle.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (run) begin
            cnt_d = tc ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/freq_gate_counter.sv
// rtl/freq_gate_counter.sv - counts edge pulses over a fixed gate window and latches the result
module freq_gate_counter
    import freq_gate_counter_pkg::*;
#(
    parameter int GATE_CYCLES = DEF_GATE_CYCLES,
    parameter int GATE_W      = DEF_GATE_W,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pos_edge,
    input  logic             start,
    input  logic             continuous,
    output logic [CNT_W-1:0] freq,
    output logic             freq_valid,
    output logic             overflow,
    output logic             busy
);

    fgc_state_e       state_q, state_d;
    logic [CNT_W-1:0] edge_cnt_q, edge_cnt_d;
    logic             ovf_q, ovf_d;
    logic [CNT_W-1:0] freq_q, freq_d;
    logic             overflow_q, overflow_d;
    logic             freq_valid_q, freq_valid_d;

    logic             timer_clear;
    logic             timer_run;
    logic             tc;
    logic             edge_sat;
    logic [CNT_W-1:0] cnt_inc;
    logic             ovf_inc;

    freq_gate_counter_gate_timer #(
        .GATE_CYCLES (GATE_CYCLES),
        .GATE_W      (GATE_W)
    ) u_gate_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (timer_clear),
        .run   (timer_run),
        .tc    (tc)
    );

    // Count including this cycle's edge, so the terminal cycle's edge reaches freq.
    assign edge_sat = &edge_cnt_q;
    assign cnt_inc  = (pos_edge && !edge_sat) ? edge_cnt_q + 1'b1 : edge_cnt_q;
    assign ovf_inc  = ovf_q | (pos_edge & edge_sat);

    always_comb begin
        state_d      = state_q;
        edge_cnt_d   = edge_cnt_q;
        ovf_d        = ovf_q;
        freq_d       = freq_q;
        overflow_d   = overflow_q;
        freq_valid_d = 1'b0;
        timer_clear  = 1'b0;
        timer_run    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                timer_clear = 1'b1;
                if (start || continuous) begin
                    state_d    = ST_COUNT;
                    edge_cnt_d = '0;
                    ovf_d      = 1'b0;
                end
            end
            ST_COUNT: begin
                timer_run  = 1'b1;
                edge_cnt_d = cnt_inc;
                ovf_d      = ovf_inc;
                if (tc) begin
                    freq_d       = cnt_inc;
                    overflow_d   = ovf_inc;
                    freq_valid_d = 1'b1;
                    if (continuous) begin
                        edge_cnt_d = '0;
                        ovf_d      = 1'b0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            edge_cnt_q   <= '0;
            ovf_q        <= 1'b0;
            freq_q       <= '0;
            overflow_q   <= 1'b0;
            freq_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            edge_cnt_q   <= edge_cnt_d;
            ovf_q        <= ovf_d;
            freq_q       <= freq_d;
            overflow_q   <= overflow_d;
            freq_valid_q <= freq_valid_d;
        end
    end

    assign freq       = freq_q;
    assign freq_valid = freq_valid_q;
    assign overflow   = overflow_q;
    assign busy       = (state_q == ST_COUNT);

endmodule

// File: tb/tb_freq_gate_counter.sv
// tb/tb_freq_gate_counter.sv - randomized and directed checks of freq_gate_counter against a window model
module tb_freq_gate_counter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, start, continuous, pos_edge;
    logic [7:0] freq0;
    logic       fv0, ov0, busy0;
    logic [1:0] freq1;
    logic       fv1, ov1, busy1;

    freq_gate_counter #(.GATE_CYCLES(10), .GATE_W(4), .CNT_W(8)) dut0 (
        .clk(clk), .rst_n(rst_n), .pos_edge(pos_edge), .start(start),
        .continuous(continuous), .freq(freq0), .freq_valid(fv0),
        .overflow(ov0), .busy(busy0)
    );

    freq_gate_counter #(.GATE_CYCLES(20), .GATE_W(5), .CNT_W(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .pos_edge(pos_edge), .start(start),
        .continuous(continuous), .freq(freq1), .freq_valid(fv1),
        .overflow(ov1), .busy(busy1)
    );

    int checks   = 0;
    int failures = 0;

    int g_len[2] = '{10, 20};
    int f_max[2] = '{255, 3};
    int m_open[2], m_el[2], m_edges[2], m_freq[2], m_ovf[2], m_valid[2];

    int vcnt0, vcnt1, busy_cnt0, cyc, last_valid_cyc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Window model: an unbounded edge tally per open window, clamped only when reported.
    task automatic model_step();
        for (int d = 0; d < 2; d++) begin
            m_valid[d] = 0;
            if (!rst_n) begin
                m_open[d] = 0; m_el[d] = 0; m_edges[d] = 0;
                m_freq[d] = 0; m_ovf[d] = 0;
            end else if (m_open[d] == 0) begin
                if (start || continuous) begin
                    m_open[d] = 1; m_el[d] = 0; m_edges[d] = 0;
                end
            end else begin
                m_edges[d] += int'(pos_edge);
                m_el[d]++;
                if (m_el[d] == g_len[d]) begin
                    m_freq[d]  = (m_edges[d] > f_max[d]) ? f_max[d] : m_edges[d];
                    m_ovf[d]   = (m_edges[d] > f_max[d]) ? 1 : 0;
                    m_valid[d] = 1;
                    if (continuous) begin
                        m_el[d] = 0; m_edges[d] = 0;
                    end else begin
                        m_open[d] = 0;
                    end
                end
            end
        end
    endtask

    task automatic step(input logic r, input logic s, input logic c, input logic p);
        rst_n = r; start = s; continuous = c; pos_edge = p;
        @(posedge clk);
        model_step();
        @(negedge clk);
        cyc++;
        check("freq0",  32'(freq0), 32'(m_freq[0]));
        check("valid0", 32'(fv0),   32'(m_valid[0]));
        check("ovf0",   32'(ov0),   32'(m_ovf[0]));
        check("busy0",  32'(busy0), 32'(m_open[0]));
        check("freq1",  32'(freq1), 32'(m_freq[1]));
        check("valid1", 32'(fv1),   32'(m_valid[1]));
        check("ovf1",   32'(ov1),   32'(m_ovf[1]));
        check("busy1",  32'(busy1), 32'(m_open[1]));
        if (fv0) vcnt0++;
        if (fv1) vcnt1++;
        if (busy0) busy_cnt0++;
    endtask

    initial begin
        cyc = 0;
        rst_n = 1'b0; start = 1'b0; continuous = 1'b0; pos_edge = 1'b0;
        step(0, 0, 0, 0);
        step(0, 0, 0, 1);
        check("rst_freq0", 32'(freq0), 32'd0);
        check("rst_busy0", 32'(busy0), 32'd0);

        // One-shot with a start pulse mid-window that must be ignored
        vcnt0 = 0; busy_cnt0 = 0;
        step(1, 1, 0, 0);
        for (int i = 0; i < 10; i++) begin
            step(1, (i == 4), 0, (i % 2 == 0));
            if (i < 9) check("oneshot_nvalid_early", 32'(fv0), 32'd0);
        end
        check("oneshot_valid_at_11", 32'(fv0), 32'd1);
        for (int i = 0; i < 15; i++) step(1, 0, 0, 1);
        check("oneshot_freq", 32'(freq0), 32'd5);
        check("oneshot_ovf", 32'(ov0), 32'd0);
        check("oneshot_nvalid", 32'(vcnt0), 32'd1);
        check("oneshot_busy_len", 32'(busy_cnt0), 32'd10);

        // Reset mid-window aborts without reporting
        vcnt0 = 0;
        step(1, 1, 0, 1);
        for (int i = 0; i < 4; i++) step(1, 0, 0, 1);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        check("midrst_freq0", 32'(freq0), 32'd0);
        check("midrst_busy0", 32'(busy0), 32'd0);
        check("midrst_ovf0", 32'(ov0), 32'd0);
        for (int i = 0; i < 12; i++) step(1, 0, 0, 0);
        check("midrst_nvalid", 32'(vcnt0), 32'd0);

        // Edges in the accept cycle, first and terminal window cycles
        vcnt0 = 0;
        step(1, 1, 0, 1);
        for (int i = 0; i < 10; i++) step(1, 0, 0, (i == 0 || i == 9));
        step(1, 0, 0, 0);
        check("boundary_freq", 32'(freq0), 32'd2);
        check("boundary_nvalid", 32'(vcnt0), 32'd1);
        for (int i = 0; i < 12; i++) step(1, 0, 0, 0);

        // Continuous: four back-to-back windows, continuous dropped in the fourth
        vcnt0 = 0; last_valid_cyc = -1;
        for (int i = 0; i < 55; i++) begin
            step(1, 0, (i < 35), (i % 2 == 1));
            if (fv0) begin
                check("cont_freq", 32'(freq0), 32'd5);
                if (last_valid_cyc >= 0) check("cont_spacing", 32'(cyc - last_valid_cyc), 32'd10);
                last_valid_cyc = cyc;
            end
        end
        check("cont_nvalid", 32'(vcnt0), 32'd4);
        check("cont_idle", 32'(busy0), 32'd0);

        // Saturation on the 2-bit, 20-cycle instance
        vcnt1 = 0;
        step(1, 1, 0, 0);
        for (int i = 0; i < 20; i++) step(1, 0, 0, (i % 2 == 0));
        step(1, 0, 0, 0);
        check("sat_freq", 32'(freq1), 32'd3);
        check("sat_ovf", 32'(ov1), 32'd1);
        step(1, 1, 0, 0);
        for (int i = 0; i < 20; i++) step(1, 0, 0, (i == 3 || i == 12));
        step(1, 0, 0, 0);
        check("sat2_freq", 32'(freq1), 32'd2);
        check("sat2_ovf", 32'(ov1), 32'd0);
        check("sat_nvalid", 32'(vcnt1), 32'd2);

        // Randomized traffic, all outputs compared against the model every cycle
        begin
            logic c;
            c = 1'b0;
            for (int i = 0; i < 1500; i++) begin
                if ($urandom_range(0, 29) == 0) c = ~c;
                step(($urandom_range(0, 149) != 0),
                     ($urandom_range(0, 7) == 0),
                     c,
                     ($urandom_range(0, 2) != 0));
            end
        end
        for (int i = 0; i < 25; i++) step(1, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
